// File: rtl/axis_drain_pkg.sv
// Shared types and limits for the burst drainer: state encoding and the length clamp.
// No logic; no latency; no backpressure.
// Imported by the drainer top and its idle timer.
package axis_drain_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } drain_state_e;

    // Largest burst equals the upstream FIFO depth.
    localparam int unsigned DRAIN_MAX_BURST = 256;

    function automatic logic [31:0] clamp_len(input logic [31:0] len, input logic [31:0] limit);
        return (len > limit) ? limit : len;
    endfunction

endpackage

// File: rtl/axis_drain_timer.sv
// Saturating idle timer; flags when it has reached cfg_timeout-1 (never when cfg_timeout is 0).
// Compare output is combinational from the timer register.
// No backpressure; the timer clears whenever run is low.
module axis_drain_timer
    import axis_drain_pkg::*;
#(
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     run,
    input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
    output logic                     expired
);

    logic [TIMEOUT_WIDTH-1:0] timer_q;
    logic [TIMEOUT_WIDTH-1:0] timer_d;

    always_comb begin
        timer_d = '0;
        if (run) begin
            timer_d = (timer_q == '1) ? timer_q : timer_q + TIMEOUT_WIDTH'(1);
        end
    end

    assign expired = (cfg_timeout != '0) && (timer_q == cfg_timeout - TIMEOUT_WIDTH'(1));

    always_ff @(posedge aclk) begin
        if (areset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/axis_burst_drainer.sv
// Drains a stream FIFO in fixed-length packets with regenerated TLAST; flushes residue on idle timeout.
// Zero-latency pass-through during a burst; bursts start one cycle after the start condition.
// In a burst S_AXIS_TREADY follows M_AXIS_TREADY; in IDLE the drainer holds the FIFO off.
module axis_burst_drainer
    import axis_drain_pkg::*;
#(
    parameter int TDATA_WIDTH   = 128,
    parameter int MAX_BURST     = DRAIN_MAX_BURST,
    parameter int COUNT_WIDTH   = $clog2(MAX_BURST) + 1,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [TDATA_WIDTH/8-1:0] S_AXIS_TKEEP,
    input  logic                     S_AXIS_TLAST,
    input  logic                     S_AXIS_TVALID,
    output logic                     S_AXIS_TREADY,
    output logic [TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [TDATA_WIDTH/8-1:0] M_AXIS_TKEEP,
    output logic                     M_AXIS_TLAST,
    output logic                     M_AXIS_TVALID,
    input  logic                     M_AXIS_TREADY,
    input  logic [31:0]              fifo_count,
    input  logic                     enable,
    input  logic [COUNT_WIDTH-1:0]   cfg_burst_len,
    input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
    output logic                     busy,
    output logic [31:0]              bursts_sent,
    output logic [31:0]              flushes_sent
);

    drain_state_e           state_q, state_d;
    logic [COUNT_WIDTH-1:0] beats_left_q, beats_left_d;
    logic                   is_flush_q, is_flush_d;
    logic [31:0]            bursts_sent_q, bursts_sent_d;
    logic [31:0]            flushes_sent_q, flushes_sent_d;

    logic [COUNT_WIDTH-1:0] fifo_cnt;
    logic [COUNT_WIDTH-1:0] eff_len;
    logic [COUNT_WIDTH-1:0] flush_len;
    logic                   start_full;
    logic                   start_flush;
    logic                   timer_run;
    logic                   timer_expired;
    logic                   unused_ok;

    // TLAST from the FIFO is meaningless here; packet boundaries come from the beat counter.
    assign unused_ok = ^{S_AXIS_TLAST, fifo_count[31:COUNT_WIDTH]};

    assign fifo_cnt  = fifo_count[COUNT_WIDTH-1:0];
    assign eff_len   = COUNT_WIDTH'(clamp_len(32'(cfg_burst_len), 32'(MAX_BURST)));
    assign flush_len = COUNT_WIDTH'(clamp_len(32'(fifo_cnt), 32'(MAX_BURST)));

    assign start_full  = enable && (eff_len != '0) && (fifo_cnt >= eff_len);
    assign start_flush = enable && timer_expired && (fifo_cnt != '0);
    assign timer_run   = (state_q == ST_IDLE) && enable && (fifo_cnt != '0)
                         && !start_full && !start_flush;

    axis_drain_timer #(
        .TIMEOUT_WIDTH(TIMEOUT_WIDTH)
    ) u_timer (
        .aclk       (aclk),
        .areset     (areset),
        .run        (timer_run),
        .cfg_timeout(cfg_timeout),
        .expired    (timer_expired)
    );

    always_comb begin
        state_d        = state_q;
        beats_left_d   = beats_left_q;
        is_flush_d     = is_flush_q;
        bursts_sent_d  = bursts_sent_q;
        flushes_sent_d = flushes_sent_q;
        M_AXIS_TVALID  = 1'b0;
        S_AXIS_TREADY  = 1'b0;
        M_AXIS_TLAST   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_full) begin
                    state_d      = ST_BURST;
                    beats_left_d = eff_len;
                    is_flush_d   = 1'b0;
                end else if (start_flush) begin
                    state_d      = ST_BURST;
                    beats_left_d = flush_len;
                    is_flush_d   = 1'b1;
                end
            end
            ST_BURST: begin
                M_AXIS_TVALID = S_AXIS_TVALID;
                S_AXIS_TREADY = M_AXIS_TREADY;
                M_AXIS_TLAST  = (beats_left_q == COUNT_WIDTH'(1));
                if (S_AXIS_TVALID && M_AXIS_TREADY) begin
                    beats_left_d = beats_left_q - COUNT_WIDTH'(1);
                    if (beats_left_q == COUNT_WIDTH'(1)) begin
                        state_d = ST_IDLE;
                        if (is_flush_q) begin
                            flushes_sent_d = flushes_sent_q + 32'd1;
                        end else begin
                            bursts_sent_d = bursts_sent_q + 32'd1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q        <= ST_IDLE;
            beats_left_q   <= '0;
            is_flush_q     <= 1'b0;
            bursts_sent_q  <= '0;
            flushes_sent_q <= '0;
        end else begin
            state_q        <= state_d;
            beats_left_q   <= beats_left_d;
            is_flush_q     <= is_flush_d;
            bursts_sent_q  <= bursts_sent_d;
            flushes_sent_q <= flushes_sent_d;
        end
    end

    assign M_AXIS_TDATA = S_AXIS_TDATA;
    assign M_AXIS_TKEEP = S_AXIS_TKEEP;
    assign busy         = (state_q == ST_BURST);
    assign bursts_sent  = bursts_sent_q;
    assign flushes_sent = flushes_sent_q;

endmodule
